lsu_mem_master: RTL and testbench

//  Load/store initiator that drives the data-memory responder port (valid/wen/readop/wmask/raddr/waddr/wdata -> rdata).

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_mem_master_if.sv | 26 ++
 rtl/lsu_store_align.sv | 17 +
 rtl/lsu_mem_master.sv | 137 +++++++++++++
 tb/tb_lsu_mem_master.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory master.
// The misalignment check is only used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  localparam logic [2:0] LSU_OP_B  = 3'd0;
  localparam logic [2:0] LSU_OP_H  = 3'd1;
  localparam logic [2:0] LSU_OP_W  = 3'd2;
  localparam logic [2:0] LSU_OP_BU = 3'd4;
  localparam logic [2:0] LSU_OP_HU = 3'd5;

  // Byte-lane mask within a 4-lane word; shifted lanes fall off the top, they never wrap.
  function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] mask;
    case (op)
      LSU_OP_B: mask = 4'b0001 << off;
      LSU_OP_H: mask = 4'b0011 << off;
      LSU_OP_W: mask = 4'b1111;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Size comes from op[1:0] for both loads and stores.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    return ((op[1:0] == 2'd1) && (off == 2'd3)) || ((op[1:0] == 2'd2) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Data-memory request/response bus between the LSU (master) and data memory (slave).
interface lsu_mem_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_wen;
  logic [2:0]        mem_readop;
  logic [7:0]        mem_wmask;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_wen, mem_readop, mem_wmask, mem_raddr, mem_waddr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_wen, mem_readop, mem_wmask, mem_raddr, mem_waddr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_store_align.sv
// Store alignment: byte-lane mask and lane-shifted store data from op and address offset.
module lsu_store_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        wmask,
  output logic [DATA_W-1:0] wdata_shifted
);

  assign wmask         = lane_mask(op, off);
  assign wdata_shifted = wdata << {off, 3'b000};

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one access in flight, IDLE->REQ->WAIT->DONE handshake to data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses without issuing them to memory.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  lsu_mem_master_if.master  mem
);

  lsu_state_e        state_q;
  logic              in_ready_q;
  logic              mem_valid_q;
  logic              out_valid_q;
  logic              out_err_q;
  logic [DATA_W-1:0] out_rdata_q;
  logic              wen_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              acc_misaligned;
  logic [3:0]        lane_wmask;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] resp_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign acc_misaligned = misaligned(in_op, in_addr[1:0]);
`else
  assign acc_misaligned = 1'b0;
`endif

  lsu_store_align #(
    .DATA_W(DATA_W)
  ) u_store_align (
    .op           (op_q),
    .off          (addr_q[1:0]),
    .wdata        (wdata_q),
    .wmask        (lane_wmask),
    .wdata_shifted(lane_wdata)
  );

  // Stores complete on the write-ack but report no data.
  assign resp_data = wen_q ? '0 : mem.mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_rdata_q <= '0;
      wen_q       <= 1'b0;
      op_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            wen_q       <= in_wen;
            op_q        <= in_op;
            addr_q      <= in_addr;
            wdata_q     <= in_wdata;
            in_ready_q  <= 1'b0;
            out_err_q   <= acc_misaligned;
            out_rdata_q <= '0;
            if (acc_misaligned) begin
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              mem_valid_q <= 1'b1;
              state_q     <= StReq;
            end
          end
        end
        StReq: begin
          if (mem.mem_ready) begin
            mem_valid_q <= 1'b0;
            if (mem.mem_rvalid) begin
              out_rdata_q <= resp_data;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (mem.mem_rvalid) begin
            out_rdata_q <= resp_data;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // in_ready is low here, so a new request cannot be taken in the release cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_rdata      = out_rdata_q;
  assign out_err        = out_err_q;

  assign mem.mem_valid  = mem_valid_q;
  assign mem.mem_wen    = wen_q;
  assign mem.mem_readop = wen_q ? 3'd0 : op_q;
  assign mem.mem_raddr  = addr_q;
  assign mem.mem_waddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_wmask  = {4'b0000, (wen_q ? lane_wmask : 4'b0000)};
  assign mem.mem_wdata  = wen_q ? lane_wdata : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against a transaction-level reference model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_op;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_wen   (in_wen),
    .in_op    (in_op),
    .in_addr  (in_addr),
    .in_wdata (in_wdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_rdata(out_rdata),
    .out_err  (out_err),
    .mem      (mif.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic model_misaligned(input logic [2:0] op, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    int sz = int'(op) % 4;
    int off = int'(addr[1:0]);
    return (sz == 1 && off == 3) || (sz == 2 && off != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_wmask(input logic [2:0] op, input logic [31:0] addr);
    int off = int'(addr[1:0]);
    int m;
    if (op == 3'd0) m = 1 << off;
    else if (op == 3'd1) m = 3 << off;
    else if (op == 3'd2) m = 15;
    else m = 0;
    return 32'(m % 16);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [31:0] addr);
    logic [63:0] w = {32'd0, wdata} << (8 * int'(addr[1:0]));
    return w[31:0];
  endfunction

  task automatic check_req(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata);
    check_eq("mem_wen", 32'(mif.mem_wen), 32'(wen));
    if (wen) begin
      check_eq("mem_readop_st", 32'(mif.mem_readop), 32'd0);
      check_eq("mem_waddr", mif.mem_waddr, addr & 32'hFFFF_FFFC);
      check_eq("mem_wmask", 32'(mif.mem_wmask), model_wmask(op, addr));
      check_eq("mem_wdata", mif.mem_wdata, model_wdata(wdata, addr));
    end else begin
      check_eq("mem_readop_ld", 32'(mif.mem_readop), 32'(op));
      check_eq("mem_raddr", mif.mem_raddr, addr);
    end
  endtask

  // One full access; memory and WBU behaviour follow the given delays.
  task automatic run_access(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int rdy_dly, input int rv_dly, input int out_dly);
    logic        mis;
    logic [31:0] exp_rd;
    mis    = model_misaligned(op, addr);
    exp_rd = (wen || mis) ? 32'd0 : rdata;
    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_wen = wen; in_op = op; in_addr = addr; in_wdata = wdata;
    @(negedge clk);
    in_valid = 1'b0; in_op = 3'($urandom); in_addr = $urandom; in_wdata = $urandom;
    if (!mis) begin
      for (int c = 0; c <= rdy_dly; c++) begin
        check_eq("mem_valid_req", 32'(mif.mem_valid), 32'd1);
        check_eq("out_valid_req", 32'(out_valid), 32'd0);
        check_eq("in_ready_req", 32'(in_ready), 32'd0);
        check_req(wen, op, addr, wdata);
        if (c < rdy_dly) begin
          mif.mem_ready  = 1'b0;
          mif.mem_rvalid = 1'($urandom_range(0, 1));
          mif.mem_rdata  = $urandom;
        end else begin
          mif.mem_ready  = 1'b1;
          mif.mem_rvalid = (rv_dly == 0);
          mif.mem_rdata  = (rv_dly == 0) ? rdata : $urandom;
        end
        @(negedge clk);
      end
      mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0;
      for (int c = 1; c <= rv_dly; c++) begin
        check_eq("mem_valid_wait", 32'(mif.mem_valid), 32'd0);
        check_eq("out_valid_wait", 32'(out_valid), 32'd0);
        if (c == rv_dly) begin
          mif.mem_rvalid = 1'b1; mif.mem_rdata = rdata;
        end
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
      end
    end
    for (int c = 0; c <= out_dly; c++) begin
      check_eq("out_valid_done", 32'(out_valid), 32'd1);
      check_eq("out_rdata", out_rdata, exp_rd);
      check_eq("out_err", 32'(out_err), 32'(mis));
      check_eq("in_ready_done", 32'(in_ready), 32'd0);
      check_eq("mem_valid_done", 32'(mif.mem_valid), 32'd0);
      mif.mem_rvalid = 1'($urandom_range(0, 1));
      mif.mem_rdata  = $urandom;
      out_ready      = (c == out_dly);
      in_valid       = (c == out_dly);
      @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0; mif.mem_rvalid = 1'b0;
    check_eq("out_valid_release", 32'(out_valid), 32'd0);
    check_eq("in_ready_release", 32'(in_ready), 32'd1);
    check_eq("no_same_cycle_accept", 32'(mif.mem_valid), 32'd0);
  endtask

  logic [2:0] ld_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_op = 3'd0; in_addr = 32'd0;
    in_wdata = 32'd0; out_ready = 1'b0;
    mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_rdata", out_rdata, 32'd0);
    check_eq("rst_out_err", 32'(out_err), 32'd0);
    check_eq("rst_mem_valid", 32'(mif.mem_valid), 32'd0);
    check_eq("rst_mem_wen", 32'(mif.mem_wen), 32'd0);
    check_eq("rst_mem_wmask", 32'(mif.mem_wmask), 32'd0);
    check_eq("rst_mem_waddr", mif.mem_waddr, 32'd0);
    check_eq("rst_mem_raddr", mif.mem_raddr, 32'd0);
    check_eq("rst_mem_wdata", mif.mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready_after", 32'(in_ready), 32'd1);

    // Directed scenarios.
    run_access(1'b0, 3'd2, 32'h8000_0008, 32'd0, 32'hDEAD_BEEF, 0, 0, 0);
    run_access(1'b1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 32'h1111_1111, 0, 0, 0);
    run_access(1'b1, 3'd1, 32'h8000_0002, 32'h0000_1234, 32'd0, 3, 1, 0);
    run_access(1'b0, 3'd4, 32'h8000_0011, 32'd0, 32'h0000_00C3, 0, 3, 2);
    run_access(1'b0, 3'd2, 32'h8000_0002, 32'd0, 32'hCAFE_F00D, 0, 0, 1);
    run_access(1'b1, 3'd1, 32'h8000_0003, 32'hFFFF_5AA5, 32'd0, 1, 0, 0);
    run_access(1'b1, 3'd7, 32'h8000_0001, 32'h1234_5678, 32'd0, 0, 0, 0);

    // Reset while waiting for the response; the late response must be dropped.
    @(negedge clk);
    in_valid = 1'b1; in_wen = 1'b0; in_op = 3'd2; in_addr = 32'h8000_0100;
    @(negedge clk);
    in_valid = 1'b0; mif.mem_ready = 1'b1;
    @(negedge clk);
    mif.mem_ready = 1'b0;
    check_eq("rst6_wait_mem_valid", 32'(mif.mem_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst6_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst6_mem_valid", 32'(mif.mem_valid), 32'd0);
    rst_n = 1'b1; mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mif.mem_rvalid = 1'b0;
    check_eq("rst6_late_rvalid", 32'(out_valid), 32'd0);
    check_eq("rst6_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_eq("rst6_still_idle", 32'(out_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic       w;
      logic [2:0] op;
      w  = 1'($urandom_range(0, 1));
      op = w ? 3'($urandom_range(0, 7)) : ld_ops[$urandom_range(0, 4)];
      run_access(w, op, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
